// File: rtl/router_pkg.sv
// Shared framing definitions for the router link: sync byte, header field
// positions, payload length and the encap/decap FSM state encoding.
package router_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         SYNC_MSB      = 63;
  localparam int         SYNC_LSB      = 56;
  localparam int         DST_MSB       = 18;
  localparam int         DST_LSB       = 9;
  localparam int         HDR_MSB       = 8;
  localparam int         HDR_LSB       = 0;
  localparam int         PAYLOAD_WORDS = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } frame_state_t;

endpackage

// File: rtl/pkt_decap_xor_accum.sv
// Running XOR over link words with synchronous clear and enable; produces the
// frame trailer on the transmit side and the expected trailer on receive.
module xor_accum #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/pkt_decap.sv
// Receive-side frame decapsulator: drains one fixed-length Aurora frame from
// the output-port FIFO, checks sync and XOR trailer, and reports the payload.
module pkt_decap
  import router_pkg::*;
#(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_decap_pkt,
  input  logic                         empty_output_port_0,
  input  logic [AURORA_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                         rd_output_port_0,
  output logic                         busy,
  output logic                         done_decap_pkt,
  output logic [8:0]                   header_pkt_recv,
  output logic [ADDR_WIDTH-1:0]        dst_addr_arbiter_recv,
  output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
  output logic                         frame_err
);

  localparam logic [4:0] FRAME_WORDS  = 5'(NUMBER_PACKET);
  localparam logic [4:0] PAYLOAD_LAST = 5'(PAYLOAD_WORDS);
  localparam int         TAIL_LSB     = (PAYLOAD_WORDS - 1) * AURORA_DATA_WIDTH;
  localparam int         TAIL_BITS    = DATA_DFX_WIDTH - TAIL_LSB;

  frame_state_t                  state;
  logic [4:0]                    issue_cnt;
  logic [4:0]                    cap_idx;
  logic                          cap_vld;
  logic                          err_acc;
  logic [8:0]                    hdr_shadow;
  logic [ADDR_WIDTH-1:0]         dst_shadow;
  logic [DATA_DFX_WIDTH-1:0]     pay_shadow;
  logic [AURORA_DATA_WIDTH-1:0]  xor_val;
  logic [10:0]                   slice_base;
  logic                          xor_clear;
  logic                          xor_en;

  assign rd_output_port_0 = (state == RUN) && !empty_output_port_0 && (issue_cnt < FRAME_WORDS);
  assign busy             = (state != IDLE);
  assign slice_base       = 11'(cap_idx - 5'd1) * 11'(AURORA_DATA_WIDTH);
  assign xor_clear        = (state == IDLE) && start_decap_pkt;
  assign xor_en           = cap_vld && (cap_idx != 5'd0) && (cap_idx <= PAYLOAD_LAST);

  xor_accum #(
    .WIDTH (AURORA_DATA_WIDTH)
  ) u_xor_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (xor_clear),
    .en    (xor_en),
    .din   (fifo_rd_data),
    .acc   (xor_val)
  );

  // Fields are gathered in shadow registers and published together on the
  // trailer word, so a stalled or aborted frame never exposes partial data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      issue_cnt             <= '0;
      cap_idx               <= '0;
      cap_vld               <= 1'b0;
      err_acc               <= 1'b0;
      hdr_shadow            <= '0;
      dst_shadow            <= '0;
      pay_shadow            <= '0;
      done_decap_pkt        <= 1'b0;
      header_pkt_recv       <= '0;
      dst_addr_arbiter_recv <= '0;
      data_dfx_recv         <= '0;
      frame_err             <= 1'b0;
    end else begin
      cap_vld        <= rd_output_port_0;
      done_decap_pkt <= 1'b0;
      case (state)
        IDLE: begin
          if (start_decap_pkt) begin
            state                 <= RUN;
            issue_cnt             <= '0;
            cap_idx               <= '0;
            err_acc               <= 1'b0;
            header_pkt_recv       <= '0;
            dst_addr_arbiter_recv <= '0;
            data_dfx_recv         <= '0;
            frame_err             <= 1'b0;
          end
        end
        RUN: begin
          if (rd_output_port_0) begin
            issue_cnt <= issue_cnt + 5'd1;
          end
          if (cap_vld) begin
            cap_idx <= cap_idx + 5'd1;
            if (cap_idx == 5'd0) begin
              hdr_shadow <= fifo_rd_data[HDR_MSB:HDR_LSB];
              dst_shadow <= fifo_rd_data[DST_MSB:DST_LSB];
              if (fifo_rd_data[SYNC_MSB:SYNC_LSB] != SYNC_BYTE) begin
                err_acc <= 1'b1;
              end
            end else if (cap_idx < PAYLOAD_LAST) begin
              pay_shadow[slice_base +: AURORA_DATA_WIDTH] <= fifo_rd_data;
            end else if (cap_idx == PAYLOAD_LAST) begin
              pay_shadow[DATA_DFX_WIDTH-1:TAIL_LSB] <= fifo_rd_data[TAIL_BITS-1:0];
            end else begin
              header_pkt_recv       <= hdr_shadow;
              dst_addr_arbiter_recv <= dst_shadow;
              data_dfx_recv         <= pay_shadow;
              frame_err             <= err_acc | (fifo_rd_data != xor_val);
              done_decap_pkt        <= 1'b1;
              state                 <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_decap.sv
// Self-checking bench for pkt_decap: FIFO model, frame-level reference model,
// directed boundary frames and randomized frames with random FIFO stalls.
module tb_pkt_decap;

  typedef struct {
    logic [8:0]    hdr;
    logic [9:0]    dst;
    logic [1033:0] data;
    logic          err;
    int            done_rel;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start_decap_pkt;
  logic          empty_output_port_0;
  logic [63:0]   fifo_rd_data;
  logic          rd_output_port_0;
  logic          busy;
  logic          done_decap_pkt;
  logic [8:0]    header_pkt_recv;
  logic [9:0]    dst_addr_arbiter_recv;
  logic [1033:0] data_dfx_recv;
  logic          frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] fifo_q[$];
  int          stall_q[$];
  exp_t        exp_q[$];
  exp_t        cur;
  logic [63:0] frame_w[0:18];
  int          frame_stall[0:18];

  bit            model_busy  = 0;
  bit            checking_en = 0;
  int            edge_cnt    = 0;
  int            start_edge  = 0;
  int            stall_left  = 0;
  int            frame_pops  = 0;
  int            total_pops  = 0;
  int            done_count  = 0;
  logic [8:0]    held_hdr    = '0;
  logic [9:0]    held_dst    = '0;
  logic [1033:0] held_data   = '0;
  logic          held_err    = 1'b0;

  pkt_decap dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start_decap_pkt       (start_decap_pkt),
    .empty_output_port_0   (empty_output_port_0),
    .fifo_rd_data          (fifo_rd_data),
    .rd_output_port_0      (rd_output_port_0),
    .busy                  (busy),
    .done_decap_pkt        (done_decap_pkt),
    .header_pkt_recv       (header_pkt_recv),
    .dst_addr_arbiter_recv (dst_addr_arbiter_recv),
    .data_dfx_recv         (data_dfx_recv),
    .frame_err             (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkData(input string name, input logic [1033:0] act, input logic [1033:0] exp);
    logic [1087:0] a;
    logic [1087:0] e;
    a = 1088'(act);
    e = 1088'(exp);
    for (int k = 0; k < 17; k++) begin
      checkOutput($sformatf("%s[%0d]", name, k), a[k*64 +: 64], e[k*64 +: 64]);
    end
  endtask

  // Reference: what a frame must decode to, straight from the frame format.
  function automatic exp_t modelFrame();
    exp_t          e;
    logic [1087:0] pad;
    logic [63:0]   x;
    pad = '0;
    x   = '0;
    e.done_rel = 21;
    for (int k = 1; k <= 17; k++) begin
      pad[(k-1)*64 +: 64] = frame_w[k];
      x = x ^ frame_w[k];
    end
    for (int k = 0; k < 18; k++) e.done_rel += frame_stall[k];
    e.hdr  = frame_w[0][8:0];
    e.dst  = frame_w[0][18:9];
    e.data = pad[1033:0];
    e.err  = (frame_w[0][63:56] != 8'hA5) || (frame_w[18] != x);
    return e;
  endfunction

  // FIFO model plus start acceptance, evaluated on each active edge.
  always @(posedge clk) begin
    bit accept;
    accept = rst_n && start_decap_pkt && !model_busy;
    if (model_busy && (edge_cnt - start_edge + 1) == cur.done_rel) model_busy = 0;
    if (accept) begin
      checkOutput("start_has_frame", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      start_edge = edge_cnt + 1;
      model_busy = 1;
      frame_pops = 0;
    end
    if (rst_n && rd_output_port_0) begin
      checkOutput("pop_nonempty", 64'(fifo_q.size() > 0), 64'd1);
      if (fifo_q.size() > 0) begin
        fifo_rd_data <= fifo_q.pop_front();
        stall_left = stall_q.pop_front();
        frame_pops++;
        total_pops++;
      end
    end else if (stall_left > 0) begin
      stall_left--;
    end
    empty_output_port_0 <= (fifo_q.size() == 0) || (stall_left != 0);
    edge_cnt++;
  end

  always @(negedge clk) begin
    if (rst_n && done_decap_pkt) done_count++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int rel;
    bit exp_done;
    if (rst_n && checking_en) begin
      rel      = edge_cnt - start_edge + 1;
      exp_done = model_busy && (rel == cur.done_rel);
      checkOutput("done", 64'(done_decap_pkt), 64'(exp_done));
      checkOutput("busy", 64'(busy), 64'(model_busy));
      checkOutput("rd", 64'(rd_output_port_0),
                  64'(model_busy && !empty_output_port_0 && frame_pops < 19));
      if (exp_done) begin
        checkOutput("hdr", 64'(header_pkt_recv), 64'(cur.hdr));
        checkOutput("dst", 64'(dst_addr_arbiter_recv), 64'(cur.dst));
        checkOutput("frame_err", 64'(frame_err), 64'(cur.err));
        checkOutput("pops", 64'(frame_pops), 64'd19);
        checkData("data", data_dfx_recv, cur.data);
        held_hdr  = cur.hdr;
        held_dst  = cur.dst;
        held_data = cur.data;
        held_err  = cur.err;
      end else if (model_busy) begin
        checkOutput("frame_err_run", 64'(frame_err), 64'd0);
      end else begin
        checkOutput("hdr_hold", 64'(header_pkt_recv), 64'(held_hdr));
        checkOutput("dst_hold", 64'(dst_addr_arbiter_recv), 64'(held_dst));
        checkOutput("err_hold", 64'(frame_err), 64'(held_err));
        checkData("data_hold", data_dfx_recv, held_data);
      end
    end
  end

  task automatic buildClean(input logic [9:0] dst, input logic [8:0] hdr);
    logic [63:0] x;
    x = '0;
    frame_w[0] = {8'hA5, 37'd0, dst, hdr};
    for (int k = 1; k <= 17; k++) begin
      frame_w[k] = {8{8'(k)}};
      x = x ^ frame_w[k];
    end
    frame_w[18] = x;
    for (int k = 0; k <= 18; k++) frame_stall[k] = 0;
  endtask

  task automatic loadFrame();
    for (int k = 0; k <= 18; k++) begin
      fifo_q.push_back(frame_w[k]);
      stall_q.push_back(frame_stall[k]);
    end
    exp_q.push_back(modelFrame());
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start_decap_pkt = 1'b1;
    @(negedge clk);
    start_decap_pkt = 1'b0;
  endtask

  task automatic applyStimulus();
    loadFrame();
    pulseStart();
  endtask

  task automatic waitDone(input int limit, output int rel_seen);
    rel_seen = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_decap_pkt) begin
        rel_seen = edge_cnt - start_edge + 1;
        break;
      end
    end
    if (rel_seen < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRel(input int target);
    for (int i = 0; i < 60 && (edge_cnt - start_edge + 1) < target; i++) @(negedge clk);
  endtask

  task automatic flushModel();
    model_busy = 0;
    fifo_q.delete();
    stall_q.delete();
    exp_q.delete();
    stall_left = 0;
    frame_pops = 0;
    held_hdr   = '0;
    held_dst   = '0;
    held_data  = '0;
    held_err   = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done_decap_pkt), 64'd0);
    checkOutput({tag, "_rd"}, 64'(rd_output_port_0), 64'd0);
    checkOutput({tag, "_hdr"}, 64'(header_pkt_recv), 64'd0);
    checkOutput({tag, "_dst"}, 64'(dst_addr_arbiter_recv), 64'd0);
    checkOutput({tag, "_err"}, 64'(frame_err), 64'd0);
    checkData({tag, "_data"}, data_dfx_recv, '0);
  endtask

  initial begin
    int rel;
    int pops0;
    int dones0;
    logic [63:0] x;
    rst_n = 1'b0;
    start_decap_pkt = 1'b0;
    empty_output_port_0 = 1'b1;
    fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checking_en = 1;

    $display("[TB] clean frame");
    buildClean(10'h2A5, 9'h1F3);
    applyStimulus();
    waitDone(60, rel);
    checkOutput("clean_latency", 64'(rel), 64'd21);
    checkOutput("clean_dst", 64'(dst_addr_arbiter_recv), 64'h2A5);
    checkOutput("clean_hdr", 64'(header_pkt_recv), 64'h1F3);
    checkOutput("clean_err", 64'(frame_err), 64'd0);
    checkOutput("clean_word1", data_dfx_recv[63:0], 64'h0101010101010101);
    checkOutput("clean_word16", data_dfx_recv[1023:960], 64'h1010101010101010);
    checkOutput("clean_tail", 64'(data_dfx_recv[1033:1024]), 64'h111);
    repeat (2) @(negedge clk);

    $display("[TB] bad trailer");
    buildClean(10'h2A5, 9'h1F3);
    frame_w[18][0] = ~frame_w[18][0];
    pops0 = total_pops;
    applyStimulus();
    waitDone(60, rel);
    checkOutput("badtrl_err", 64'(frame_err), 64'd1);
    checkOutput("badtrl_latency", 64'(rel), 64'd21);
    checkOutput("badtrl_pops", 64'(total_pops - pops0), 64'd19);
    repeat (2) @(negedge clk);

    $display("[TB] bad sync");
    buildClean(10'h2A5, 9'h1F3);
    frame_w[0][63:56] = 8'h00;
    applyStimulus();
    waitDone(60, rel);
    checkOutput("badsync_err", 64'(frame_err), 64'd1);
    checkOutput("badsync_dst", 64'(dst_addr_arbiter_recv), 64'h2A5);
    checkOutput("badsync_hdr", 64'(header_pkt_recv), 64'h1F3);
    repeat (2) @(negedge clk);

    $display("[TB] stalls");
    buildClean(10'h2A5, 9'h1F3);
    frame_stall[5]  = 3;
    frame_stall[17] = 2;
    applyStimulus();
    waitDone(80, rel);
    checkOutput("stall_latency", 64'(rel), 64'd26);
    checkOutput("stall_word1", data_dfx_recv[63:0], 64'h0101010101010101);
    checkOutput("stall_err", 64'(frame_err), 64'd0);
    repeat (2) @(negedge clk);

    $display("[TB] start while busy");
    buildClean(10'h155, 9'h0AA);
    pops0  = total_pops;
    dones0 = done_count;
    applyStimulus();
    waitRel(8);
    start_decap_pkt = 1'b1;
    @(negedge clk);
    start_decap_pkt = 1'b0;
    waitDone(60, rel);
    repeat (4) @(negedge clk);
    checkOutput("busy_start_pops", 64'(total_pops - pops0), 64'd19);
    checkOutput("busy_start_dones", 64'(done_count - dones0), 64'd1);

    $display("[TB] back-to-back");
    pops0  = total_pops;
    dones0 = done_count;
    buildClean(10'h2A5, 9'h1F3);
    loadFrame();
    buildClean(10'h03C, 9'h0A5);
    loadFrame();
    pulseStart();
    waitDone(60, rel);
    start_decap_pkt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start_decap_pkt = 1'b0;
    waitDone(60, rel);
    checkOutput("b2b_latency", 64'(rel), 64'd21);
    checkOutput("b2b_dst", 64'(dst_addr_arbiter_recv), 64'h03C);
    repeat (3) @(negedge clk);
    checkOutput("b2b_pops", 64'(total_pops - pops0), 64'd38);
    checkOutput("b2b_dones", 64'(done_count - dones0), 64'd2);

    $display("[TB] randomized frames");
    for (int f = 0; f < 24; f++) begin
      x = '0;
      frame_w[0] = {(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA5),
                    37'($urandom), 10'($urandom), 9'($urandom)};
      for (int k = 1; k <= 17; k++) begin
        frame_w[k] = {$urandom, $urandom};
        x = x ^ frame_w[k];
      end
      frame_w[18] = ($urandom_range(0, 3) == 0) ? (x ^ (64'd1 << $urandom_range(0, 63))) : x;
      for (int k = 0; k <= 18; k++) begin
        frame_stall[k] = (k < 18 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      applyStimulus();
      waitDone(150, rel);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-frame");
    buildClean(10'h2A5, 9'h1F3);
    applyStimulus();
    waitRel(10);
    rst_n = 1'b0;
    flushModel();
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    buildClean(10'h2A5, 9'h1F3);
    applyStimulus();
    waitDone(60, rel);
    checkOutput("post_reset_latency", 64'(rel), 64'd21);
    checkOutput("post_reset_dst", 64'(dst_addr_arbiter_recv), 64'h2A5);
    checkOutput("post_reset_err", 64'(frame_err), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pkt_decap.md
# pkt_decap

Receive-side frame decapsulator for the router output port. On `start_decap_pkt` it drains one fixed-length frame of `NUMBER_PACKET` 64-bit Aurora words from output port 0's FIFO and checks the sync byte and XOR checksum. It then reassembles the `DATA_DFX_WIDTH` payload and reports header, destination address and payload to the controller with a one-cycle `done_decap_pkt` pulse. It is the receive-side counterpart of the frame encapsulator driven by `start_encap_pkt`.

## Interface
- `DATA_WIDTH`, 1024, payload data bits
- `ADDR_WIDTH`, 10, BRAM address bits
- `DATA_DFX_WIDTH`, `DATA_WIDTH+ADDR_WIDTH`, reassembled payload width
- `AURORA_DATA_WIDTH`, 64, link word width
- `NUMBER_PACKET`, 19, words per frame (header + 17 payload + trailer)
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start_decap_pkt`  in  1  one-cycle request to decapsulate the next frame
- `empty_output_port_0`  in  1  FIFO empty
- `fifo_rd_data`  in  64  FIFO read data, valid the cycle after `rd_output_port_0`
- `rd_output_port_0`  out  1  FIFO pop
- `busy`  out  1  frame in progress
- `done_decap_pkt`  out  1  one-cycle completion pulse
- `header_pkt_recv`  out  9  header field of the frame
- `dst_addr_arbiter_recv`  out  `ADDR_WIDTH`  destination BRAM address
- `data_dfx_recv`  out  `DATA_DFX_WIDTH`  reassembled {addr, data}
- `frame_err`  out  1  sync or checksum failure, valid with `done_decap_pkt`

## Operation
Frame format:
- **Word 0 (header):** [63:56] = 8'hA5 sync; [18:9] = dst_addr; [8:0] = header_pkt; other bits ignored.
- **Words 1..17 (payload):** word k holds bits [64k-1 : 64(k-1)] of a 1088-bit padded vector. `data_dfx_recv` = padded[1033:0]; bits [1087:1034] are ignored.
- **Word 18 (trailer):** XOR of words 1..17.

FSM states are IDLE, RUN and DONE:
- **IDLE → RUN:** on `start_decap_pkt`. Clear the issue and capture counters, the running XOR and the error flag.
- **RUN:**
  - `rd_output_port_0` = RUN && !empty && issue_cnt < `NUMBER_PACKET` (combinational).
  - A capture flag is registered from `rd_output_port_0`. On a capture cycle, store `fifo_rd_data` by capture index: header fields, payload slice, or trailer compare.
  - The running XOR accumulates words 1..17.
  - Sync mismatch sets the error flag; trailer ≠ XOR sets the error flag.
  - After capture index 18 is stored → DONE.
- **DONE:** `done_decap_pkt` = 1 for exactly one cycle → IDLE.

Output and boundary behaviour:
- Outputs `header_pkt_recv`, `dst_addr_arbiter_recv`, `data_dfx_recv` and `frame_err` hold their values until the next frame's start clears/overwrites them. `frame_err` clears at start.
- A frame with an error is still fully consumed (19 pops), so the link stays aligned.
- `start_decap_pkt` while `busy` is ignored.
- FIFO empty mid-frame stalls reading with no timeout. Partial data is never reported.
- Counters are 5 bits; no wrap occurs within a frame.
- `busy` = RUN or DONE.
- Reset mid-frame aborts to IDLE. All outputs return to 0. Words already popped are lost, and upstream must resynchronise.

## Timing
- Reset values: every output 0, state IDLE.
- FIFO read latency is 1 cycle. The first pop occurs the cycle after start is sampled.
- No stalls: pops on cycles 1..19, captures on cycles 2..20, DONE/`done_decap_pkt` on cycle 21 (start sampled at cycle 0).
- Each empty cycle adds exactly one cycle of latency.
- `start_decap_pkt` in the same cycle as `done_decap_pkt` is ignored (block still busy). The earliest accepted restart is the cycle after `done_decap_pkt`.

## Structure
- A shared package `router_pkg` holds:
  - `SYNC_BYTE` = 8'hA5
  - header bit-field positions
  - `PAYLOAD_WORDS` = 17
  - the FSM state encoding (shared with the encapsulator)
- One natural sub-module, `xor_accum`: 64-bit running XOR with clear and enable, reusable by the encapsulator for trailer generation.

## Test plan
- **Clean frame:** header A5 / dst=10'h2A5 / hdr=9'h1F3, payload words 0x0101..0x1111 replicated, correct trailer, FIFO never empty → 19 pops, done at cycle 21, `dst_addr_arbiter_recv`=10'h2A5, `header_pkt_recv`=9'h1F3, `frame_err`=0, `data_dfx_recv` matches the packed vector.
- **Bad trailer:** same frame with trailer bit 0 flipped → `frame_err`=1, still exactly 19 pops, `done_decap_pkt` asserted.
- **Bad sync:** header [63:56]=8'h00 → `frame_err`=1, other fields still captured.
- **Stalls:** FIFO empty for 3 cycles after word 5 and 2 cycles after word 17 → done at cycle 26, data identical to the clean case.
- **Start while busy:** second start at cycle 8 → ignored, exactly one done and 19 pops. Back-to-back frames with start the cycle after done → 38 pops, two done pulses.
- **Reset mid-frame:** `rst_n` low at cycle 10 → all outputs 0 immediately; a new start after release decodes a fresh clean frame correctly.
